ofdm_frame_sched: RTL and testbench
===================================

# ofdm_frame_sched

Frame/symbol scheduler downstream of the SOP filter. It takes the filtered start-of-frame pulse and the sync flag and runs a search/track state machine with a free-running frame counter. It realigns that counter on in-window SOPs and declares loss after repeated misses. From the counter it generates per-symbol strobes (CP skip, useful-sample gate, FFT start) for the FFT front end, with a ready handshake toward the FFT.

## Interface
- N_symb, 50: OFDM symbols per frame
- fftsize, 1024: useful samples per symbol
- cpsize, 32: cyclic-prefix samples per symbol
- SOP_LAT, 21: frame position of the sample following an on-time sop_in; must be < fftsize+cpsize
- WIN, 3: SOP acceptance half-window, in samples
- MAX_MISS, 4: consecutive missed frames before loss, 1..15
- clk  in  1  sample clock
- rst  in  1  asynchronous, active-low reset
- sop_in  in  1  filtered start-of-frame pulse, one cycle
- found_sync  in  1  sync-qualified flag from the SOP filter
- delay_sop  in  6  signed SOP offset estimate, sampled with sop_in
- fft_ready  in  1  FFT can accept a new symbol
- state  out  2  0=SEARCH, 1=TRACK
- locked  out  1  high in TRACK
- frame_start  out  1  pulse at frame position 0
- sym_start  out  1  pulse at the first useful sample of an accepted symbol
- samp_valid  out  1  useful-sample gate of an accepted symbol
- sym_idx  out  clog2(N_symb)  current symbol index
- sym_drop  out  1  pulse when a symbol is skipped because fft_ready was low
- lost  out  1  pulse on the TRACK→SEARCH transition
- frame_delay  out  6  delay_sop latched at the last accepted SOP
- frame_cnt  out  16  frames completed in TRACK (stats)
- miss_cnt  out  4  current consecutive-miss count (stats)

## Operation
- N_spfr = fftsize+cpsize; L_frame = N_symb·N_spfr.
- Counters:
  - pos: 0..L_frame-1.
  - sp: 0..N_spfr-1.
  - sym_idx: 0..N_symb-1.
  - All three advance together; no division is used.
  - sp wraps to 0 and sym_idx increments together.
  - pos, sp and sym_idx all wrap to 0 at pos = L_frame-1.
- SEARCH:
  - Counters and all pulse outputs are held at 0.
  - sop_in & found_sync → load pos = sp = SOP_LAT, sym_idx = 0, miss_cnt = 0; latch frame_delay; go to TRACK.
- TRACK:
  - Counters advance every cycle.
  - Hit: sop_in while pos lies in [SOP_LAT-1-WIN, SOP_LAT-1+WIN], modulo L_frame.
    - Next cycle, pos and sp load SOP_LAT and sym_idx loads 0.
    - miss_cnt clears and frame_delay latches.
  - sop_in outside the window is ignored.
  - Miss: pos reaches SOP_LAT+WIN with no hit since the last window opened → miss_cnt increments.
    - If miss_cnt reaches MAX_MISS → go to SEARCH and pulse lost.
  - found_sync low → go to SEARCH and pulse lost, regardless of miss_cnt.
- Symbol gating:
  - At sp = cpsize, if fft_ready = 1: sym_start pulses and the symbol is accepted; samp_valid is high for sp = cpsize..N_spfr-1.
  - If fft_ready = 0 at that cycle: sym_drop pulses, samp_valid stays low for that symbol, and sym_start does not pulse.
  - fft_ready is sampled only at sp = cpsize.
- frame_start pulses when pos = 0 in TRACK; frame_cnt increments at the same cycle.

## Timing
- Reset: state = SEARCH; all outputs 0; counters 0.
- sop_in accepted at cycle t → pos = SOP_LAT at t+1.
- Outputs are registered and aligned with the counter value of their cycle; there is no extra pipeline.
- Simultaneous hit and window end: the hit wins and no miss is counted.
- Simultaneous hit and found_sync low: go to SEARCH.
- A realign that moves pos backward may repeat samples. A realign in the middle of a symbol restarts symbol gating from sp = SOP_LAT, and samp_valid follows the new sp.
- Window wrap across pos = 0 is handled modulo L_frame.
- Loss (lost pulse, transition to SEARCH) happens one cycle after the miss or found_sync-low event.

## Configuration
- SCHED_STATS_EN defined: frame_cnt (saturating at 0xFFFF, cleared on entry to SEARCH) and miss_cnt are driven as described.
- SCHED_STATS_EN undefined: frame_cnt and miss_cnt outputs are tied to 0. A narrow internal miss counter still drives loss detection.

## Test plan
Bench parameters: N_symb=4, fftsize=16, cpsize=4, SOP_LAT=2, WIN=3, MAX_MISS=2; so N_spfr=20, L_frame=80.
- Acquire: found_sync=1, sop_in at t, fft_ready=1 → state=1 at t+1; sym_start at t+3, t+23, t+43, t+63; samp_valid high 16 cycles each; frame_start at t+79.
- Tracking: on-time sop_in every 80 cycles → no counter jump, miss_cnt=0, frame_cnt increments each frame.
- Early SOP: sop_in at t+77 (within window) → pos=2 at t+78 and next sym_start at t+80. sop_in at t+60 → ignored.
- Loss: no sop_in after acquire → miss_cnt=1 at t+85; lost pulses and state=0 at t+166.
- Backpressure: fft_ready=0 at t+23 → sym_drop at t+23; no samp_valid in t+23..t+38; sym_start resumes at t+43.
- Async reset asserted mid-TRACK → all outputs 0 immediately; sop_in ignored while rst=0.

Source files
------------

// File: rtl/ofdm_frame_sched.sv
// OFDM frame/symbol scheduler: search/track FSM, frame counter realignment and per-symbol FFT strobes.
// Define SCHED_STATS_EN to drive the frame_cnt / miss_cnt statistics outputs.
module ofdm_frame_sched #(
    parameter int N_symb   = 50,
    parameter int fftsize  = 1024,
    parameter int cpsize   = 32,
    parameter int SOP_LAT  = 21,
    parameter int WIN      = 3,
    parameter int MAX_MISS = 4,
    localparam int SYM_W   = (N_symb > 1) ? $clog2(N_symb) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sop_in,
    input  logic              found_sync,
    input  logic signed [5:0] delay_sop,
    input  logic              fft_ready,
    output logic [1:0]        state,
    output logic              locked,
    output logic              frame_start,
    output logic              sym_start,
    output logic              samp_valid,
    output logic [SYM_W-1:0]  sym_idx,
    output logic              sym_drop,
    output logic              lost,
    output logic signed [5:0] frame_delay,
    output logic [15:0]       frame_cnt,
    output logic [3:0]        miss_cnt
);

    localparam int N_SPFR  = fftsize + cpsize;
    localparam int L_FRAME = N_symb * N_SPFR;
    localparam int POS_W   = $clog2(L_FRAME);
    localparam int SP_W    = $clog2(N_SPFR);
`ifdef SCHED_STATS_EN
    localparam int MISS_W  = 4;
`else
    localparam int MISS_W  = $clog2(MAX_MISS + 1);
`endif

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(L_FRAME - 1);
    localparam logic [POS_W-1:0] POS_LAT  = POS_W'(SOP_LAT);
    localparam logic [POS_W-1:0] WIN_LO   = POS_W'((SOP_LAT - 1 - WIN + L_FRAME) % L_FRAME);
    localparam logic [POS_W-1:0] WIN_HI   = POS_W'((SOP_LAT - 1 + WIN) % L_FRAME);
    localparam logic [POS_W-1:0] MISS_POS = POS_W'((SOP_LAT + WIN) % L_FRAME);
    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(N_SPFR - 1);
    localparam logic [SP_W-1:0]  SP_LAT   = SP_W'(SOP_LAT);
    localparam logic [SP_W-1:0]  SP_CP    = SP_W'(cpsize);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);
    localparam bit WIN_WRAP = (WIN_LO > WIN_HI);

    typedef enum logic {SEARCH = 1'b0, TRACK = 1'b1} state_t;

    state_t             st, st_nxt;
    logic [POS_W-1:0]   pos;
    logic [SP_W-1:0]    sp;
    logic [SYM_W-1:0]   sym;
    logic [MISS_W-1:0]  miss_q;
    logic               hit_seen;
    logic               acc;
    logic               lost_q;
    logic signed [5:0]  delay_q;
    logic               trk, in_win, at_cp;
    logic               acquire, hit, miss, drop_trk;

    assign trk    = (st == TRACK);
    assign in_win = WIN_WRAP ? ((pos >= WIN_LO) || (pos <= WIN_HI))
                             : ((pos >= WIN_LO) && (pos <= WIN_HI));
    assign at_cp  = trk && (sp == SP_CP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= SEARCH;
            lost_q <= 1'b0;
        end else begin
            st     <= st_nxt;
            lost_q <= drop_trk;
        end
    end

    // Loss has priority over a same-cycle hit; a hit suppresses a same-cycle miss.
    always_comb begin
        st_nxt   = st;
        acquire  = 1'b0;
        hit      = 1'b0;
        miss     = 1'b0;
        drop_trk = 1'b0;
        case (st)
            SEARCH: begin
                if (sop_in && found_sync) begin
                    acquire = 1'b1;
                    st_nxt  = TRACK;
                end
            end
            TRACK: begin
                hit  = sop_in && in_win;
                miss = (pos == MISS_POS) && !hit_seen && !hit;
                if (!found_sync || (miss_q >= MISS_MAX)) begin
                    st_nxt   = SEARCH;
                    drop_trk = 1'b1;
                end
            end
            default: st_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos      <= '0;
            sp       <= '0;
            sym      <= '0;
            miss_q   <= '0;
            hit_seen <= 1'b0;
            acc      <= 1'b0;
            delay_q  <= '0;
        end else if (!trk) begin
            acc <= 1'b0;
            if (acquire) begin
                pos      <= POS_LAT;
                sp       <= SP_LAT;
                sym      <= '0;
                miss_q   <= '0;
                hit_seen <= 1'b1;
                delay_q  <= delay_sop;
            end
        end else if (drop_trk) begin
            pos      <= '0;
            sp       <= '0;
            sym      <= '0;
            miss_q   <= '0;
            hit_seen <= 1'b0;
            acc      <= 1'b0;
        end else begin
            if (sp == SP_CP)
                acc <= fft_ready;
            if (hit) begin
                pos      <= POS_LAT;
                sp       <= SP_LAT;
                sym      <= '0;
                miss_q   <= '0;
                hit_seen <= 1'b1;
                delay_q  <= delay_sop;
            end else begin
                // A fresh window opens: the next hit must be seen again.
                if (pos == WIN_LO)
                    hit_seen <= 1'b0;
                if (miss)
                    miss_q <= miss_q + 1'b1;
                if (pos == POS_LAST) begin
                    pos <= '0;
                    sp  <= '0;
                    sym <= '0;
                end else begin
                    pos <= pos + 1'b1;
                    if (sp == SP_LAST) begin
                        sp  <= '0;
                        sym <= sym + 1'b1;
                    end else begin
                        sp  <= sp + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cnt_q <= '0;
        else if (drop_trk)
            frame_cnt_q <= '0;
        else if (frame_start && (frame_cnt_q != 16'hFFFF))
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
    assign miss_cnt  = miss_q;
`else
    assign frame_cnt = '0;
    assign miss_cnt  = '0;
`endif

    assign state       = {1'b0, st};
    assign locked      = trk;
    assign frame_start = trk && (pos == '0);
    assign sym_start   = at_cp && fft_ready;
    assign sym_drop    = at_cp && !fft_ready;
    assign samp_valid  = trk && ((sp == SP_CP) ? fft_ready : ((sp > SP_CP) && acc));
    assign sym_idx     = sym;
    assign lost        = lost_q;
    assign frame_delay = delay_q;

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Directed bench for ofdm_frame_sched: acquire, tracking, early SOP, backpressure, loss, async reset.
module tb_ofdm_frame_sched;

`ifdef SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sop_in = 1'b0;
    logic              found_sync = 1'b0;
    logic signed [5:0] delay_sop = '0;
    logic              fft_ready = 1'b0;
    logic [1:0]        state;
    logic              locked, frame_start, sym_start, samp_valid, sym_drop, lost;
    logic [1:0]        sym_idx;
    logic signed [5:0] frame_delay;
    logic [15:0]       frame_cnt;
    logic [3:0]        miss_cnt;

    int checks = 0;
    int failures = 0;
    int fc_exp = 0;

    ofdm_frame_sched #(
        .N_symb(4), .fftsize(16), .cpsize(4), .SOP_LAT(2), .WIN(3), .MAX_MISS(2)
    ) dut (
        .clk(clk), .rst(rst), .sop_in(sop_in), .found_sync(found_sync),
        .delay_sop(delay_sop), .fft_ready(fft_ready), .state(state), .locked(locked),
        .frame_start(frame_start), .sym_start(sym_start), .samp_valid(samp_valid),
        .sym_idx(sym_idx), .sym_drop(sym_drop), .lost(lost), .frame_delay(frame_delay),
        .frame_cnt(frame_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int exp_lost);
        chk("idle_state", int'(state), 0);
        chk("idle_locked", int'(locked), 0);
        chk("idle_frame_start", int'(frame_start), 0);
        chk("idle_sym_start", int'(sym_start), 0);
        chk("idle_samp_valid", int'(samp_valid), 0);
        chk("idle_sym_idx", int'(sym_idx), 0);
        chk("idle_sym_drop", int'(sym_drop), 0);
        chk("idle_lost", int'(lost), exp_lost);
        chk("idle_frame_cnt", int'(frame_cnt), 0);
        chk("idle_miss_cnt", int'(miss_cnt), 0);
        fc_exp = 0;
    endtask

    // p: expected frame position this cycle; acc_ok: current symbol was accepted.
    task automatic check_trk(input int p, input bit acc_ok, input int m);
        chk("state", int'(state), 1);
        chk("locked", int'(locked), 1);
        chk("frame_start", int'(frame_start), int'(p == 0));
        chk("sym_idx", int'(sym_idx), p / 20);
        chk("sym_start", int'((p % 20 == 4) && fft_ready), int'(sym_start));
        chk("sym_drop", int'(sym_drop), int'((p % 20 == 4) && !fft_ready));
        chk("samp_valid", int'(samp_valid), int'((p % 20 >= 4) && acc_ok));
        chk("lost", int'(lost), 0);
        chk("frame_cnt", int'(frame_cnt), STATS ? fc_exp : 0);
        chk("miss_cnt", int'(miss_cnt), STATS ? m : 0);
        if (p == 0 && fc_exp < 65535)
            fc_exp++;
    endtask

    initial begin
        // Reset state
        repeat (2) next_cycle();
        chk_idle(0);
        chk("rst_frame_delay", int'(frame_delay), 0);
        rst = 1'b1;

        // sop_in without found_sync is ignored
        next_cycle();
        sop_in = 1'b1;
        #1 chk_idle(0);
        next_cycle();
        sop_in = 1'b0;
        #1 chk_idle(0);

        // Acquire at t, then two on-time SOPs at t+80 and t+160
        next_cycle();
        found_sync = 1'b1;
        fft_ready  = 1'b1;
        sop_in     = 1'b1;
        delay_sop  = 6'sd5;
        #1 chk_idle(0);
        for (int j = 1; j <= 160; j++) begin
            next_cycle();
            sop_in = (j == 80 || j == 160);
            #1 check_trk((j + 1) % 80, 1'b1, 0);
            if (j == 1)
                chk("acq_frame_delay", int'(frame_delay), 5);
        end

        // Out-of-window SOP at T+60 ignored; early SOP at T+77 realigns
        for (int j = 1; j <= 77; j++) begin
            next_cycle();
            sop_in = (j == 60 || j == 77);
            delay_sop = (j == 60) ? 6'sd15 : ((j == 77) ? -6'sd2 : 6'sd5);
            #1 check_trk(j + 1, 1'b1, 0);
            if (j == 61)
                chk("ignored_frame_delay", int'(frame_delay), 5);
        end

        // Backpressure on the second symbol, then no more SOPs until loss
        for (int j = 1; j <= 167; j++) begin
            next_cycle();
            sop_in    = 1'b0;
            fft_ready = (j != 23);
            #1;
            if (j <= 165)
                check_trk((j + 1) % 80, !(j >= 23 && j <= 38),
                          (j < 85) ? 0 : ((j < 165) ? 1 : 2));
            else
                chk_idle((j == 166) ? 1 : 0);
            if (j == 1)
                chk("early_frame_delay", int'(frame_delay), -2);
        end

        // Reacquire, then in-window SOP with found_sync low forces SEARCH
        next_cycle();
        sop_in    = 1'b1;
        delay_sop = -6'sd3;
        #1 chk_idle(0);
        next_cycle();
        sop_in = 1'b0;
        #1 check_trk(2, 1'b1, 0);
        chk("reacq_frame_delay", int'(frame_delay), -3);
        next_cycle();
        sop_in     = 1'b1;
        found_sync = 1'b0;
        #1 check_trk(3, 1'b1, 0);
        next_cycle();
        sop_in     = 1'b0;
        found_sync = 1'b1;
        #1 chk_idle(1);

        // Acquire once more, then assert async reset mid-TRACK
        next_cycle();
        sop_in = 1'b1;
        #1 chk_idle(0);
        for (int j = 1; j <= 4; j++) begin
            next_cycle();
            sop_in = 1'b0;
            #1 check_trk(j + 1, 1'b1, 0);
        end
        next_cycle();
        rst    = 1'b0;
        sop_in = 1'b1;
        #1 chk_idle(0);
        chk("arst_frame_delay", int'(frame_delay), 0);
        repeat (2) begin
            next_cycle();
            #1 chk_idle(0);
        end
        rst    = 1'b1;
        sop_in = 1'b0;
        next_cycle();
        #1 chk_idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
